ps2_buf_ptr: RTL
================

// Module: ps2_buf_ptr
// PURPOSE
// Pointer/occupancy tracker for the dual-port sector buffer between the IDE side (port A) and the PS2 DMA engine (port B).
// Owns AddrA/AddrB, counts buffered words and produces the status levels the PS2 DMA engine consumes:
// PB_OD_Rdy, PB_HvSpace, WithinBBlock, BBurstEnd. Sits directly upstream of the PS2 DMA engine.
// Flags ungated overflow/underflow as sticky errors and freezes the buffer.
// PARAMETERS
// AW        10   buffer address width; depth = 2**AW 16-bit words
// SECT_WDS  256  words per 512-byte sector; threshold for PB_OD_Rdy / PB_HvSpace
// PORTS
// CLK4         in   1     146.6MHz system clock
// RST          in   1     asynchronous, active-high reset
// DMA_ARM      in   1     transfer armed; rising edge latches direction
// PS2WrIDE     in   1     direction: 0 = disk->PS2 (A writes, B reads), 1 = PS2->disk (B writes, A reads)
// BufClr       in   1     synchronous clear of pointers, count, errors
// IncAddrA     in   1     one-cycle pulse: IDE side moved one word
// IncAddrB     in   1     one-cycle pulse from PS2 DMA: port B moved one word
// AddrA        out  AW    port A word address
// AddrB        out  AW    port B word address
// Count        out  AW+1  words held, 0..2**AW
// PB_OD_Rdy    out  1     >= SECT_WDS words readable by PS2 (RD state only)
// PB_HvSpace   out  1     >= SECT_WDS free words for PS2 writes (WR state only)
// WithinBBlock out  1     AddrB[6] | AddrB[5]
// BBurstEnd    out  1     AddrB[4:0] == 5'h1F
// Empty        out  1     Count == 0
// Full         out  1     Count == 2**AW
// OvfErr       out  1     sticky: writer pulse while Full
// UnfErr       out  1     sticky: reader pulse while Empty
// BEHAVIOUR
// - RST: AddrA=AddrB=0, Count=0, Empty=1, all other outputs 0, state IDLE.
// - States: IDLE, RD, WR, ERR.
//   IDLE -> RD/WR on DMA_ARM 0->1, chosen by PS2WrIDE sampled that cycle; direction then locked (PS2WrIDE ignored).
//   RD/WR -> IDLE when DMA_ARM=0. Pointers and Count are retained.
//   RD/WR -> ERR on an over/underflow. ERR -> IDLE on BufClr or DMA_ARM=0.
// - Writer/reader mapping: RD uses A=writer, B=reader. WR uses B=writer, A=reader.
//   IDLE accepts increments using the PS2WrIDE mapping sampled live.
//   ERR ignores all increments.
// - Per cycle: Count += writer_inc - reader_inc.
//   Both pulses in one cycle: both pointers advance, Count unchanged.
//   This is legal even at Full or Empty, because the net change is 0.
// - Writer pulse with Full and no reader pulse: pointer not advanced, OvfErr<=1, go ERR.
// - Reader pulse with Empty and no writer pulse: pointer not advanced, UnfErr<=1, go ERR.
// - Pointers wrap modulo 2**AW (AW'h3FF -> 0). Count never wraps.
// - BufClr has priority over increments. In the same cycle: pointers 0, Count 0, errors 0, state IDLE.
// - Registered outputs, all updated at the same edge as the pointers (1-cycle latency from pulse):
//   Count, Empty, Full, PB_OD_Rdy, PB_HvSpace, OvfErr, UnfErr.
// - PB_OD_Rdy  = (state==RD) & (next Count >= SECT_WDS).
// - PB_HvSpace = (state==WR) & (2**AW - next Count >= SECT_WDS).
// - Both are 0 in IDLE and ERR.
// - WithinBBlock and BBurstEnd are combinational decodes of the registered AddrB, valid the cycle after IncAddrB.
//   They must not glitch for a DMA state-machine sample.
// - RST asserted mid-transfer: everything returns to reset values immediately. No pulse is lost or double-counted after release.
// TESTING
// - Reset, DMA_ARM=1 with PS2WrIDE=0, 256 IncAddrA pulses -> Count=256, PB_OD_Rdy=1 the cycle after the 256th pulse; 255 pulses -> PB_OD_Rdy=0.
// - RD state, 32 IncAddrB pulses from AddrB=0 -> BBurstEnd=1 at AddrB=0x1F; WithinBBlock=1 for 0x20..0x7F, 0 at 0x80.
// - WR state, Count=768 -> PB_HvSpace=1; Count=769 -> PB_HvSpace=0; IncAddrA and IncAddrB in the same cycle at Count=1024 -> Count stays 1024, no OvfErr.
// - Fill to Full (1024), extra writer pulse -> OvfErr=1, state ERR, pointer unchanged, PB_OD_Rdy=0; BufClr -> all 0, Empty=1.
// - AddrB=0x3FF, IncAddrB -> AddrB=0x000; reader pulse at Count=0 -> UnfErr=1; RST pulsed mid-burst -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/ps2_buf_ptr.sv
// Pointer/occupancy tracker for the IDE <-> PS2 DMA sector buffer.
// Owns both port addresses, the word count and the level/status flags the DMA engine samples.
module ps2_buf_ptr #(
    parameter int AW       = 10,
    parameter int SECT_WDS = 256
) (
    input  logic          CLK4,
    input  logic          RST,
    input  logic          DMA_ARM,
    input  logic          PS2WrIDE,
    input  logic          BufClr,
    input  logic          IncAddrA,
    input  logic          IncAddrB,
    output logic [AW-1:0] AddrA,
    output logic [AW-1:0] AddrB,
    output logic [AW:0]   Count,
    output logic          PB_OD_Rdy,
    output logic          PB_HvSpace,
    output logic          WithinBBlock,
    output logic          BBurstEnd,
    output logic          Empty,
    output logic          Full,
    output logic          OvfErr,
    output logic          UnfErr
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] SECT  = (AW+1)'(SECT_WDS);

    typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;

    state_t        stateReg, stateNext;
    logic          armPrevReg;
    logic [AW-1:0] addrAReg, addrANext, addrBReg, addrBNext;
    logic [AW:0]   countReg, countNext;
    logic          ovfReg, ovfNext, unfReg, unfNext;
    logic          rdyReg, rdyNext, spcReg, spcNext;
    logic          wbbReg, wbbNext, bbeReg, bbeNext;
    logic          emptyReg, emptyNext, fullReg, fullNext;
    logic          writerIsA, wInc, rInc, advA, advB, errHit;

    always_comb begin
        stateNext = stateReg;
        countNext = countReg;
        ovfNext   = ovfReg;
        unfNext   = unfReg;
        advA      = 1'b0;
        advB      = 1'b0;
        errHit    = 1'b0;

        // IDLE follows the live direction input; RD/WR use the direction locked at arm time.
        writerIsA = (stateReg == RD) || ((stateReg == IDLE) && !PS2WrIDE);
        wInc      = (stateReg != ERR) && (writerIsA ? IncAddrA : IncAddrB);
        rInc      = (stateReg != ERR) && (writerIsA ? IncAddrB : IncAddrA);

        if (wInc && rInc) begin
            advA = 1'b1;
            advB = 1'b1;
        end else if (wInc) begin
            if (countReg == DEPTH) begin
                ovfNext = 1'b1;
                errHit  = 1'b1;
            end else begin
                countNext = countReg + 1'b1;
                advA      = writerIsA;
                advB      = !writerIsA;
            end
        end else if (rInc) begin
            if (countReg == '0) begin
                unfNext = 1'b1;
                errHit  = 1'b1;
            end else begin
                countNext = countReg - 1'b1;
                advA      = !writerIsA;
                advB      = writerIsA;
            end
        end

        case (stateReg)
            IDLE:    if (DMA_ARM && !armPrevReg) stateNext = PS2WrIDE ? WR : RD;
            RD, WR:  if (!DMA_ARM) stateNext = IDLE;
            ERR:     if (!DMA_ARM) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (errHit) stateNext = ERR;

        if (BufClr) begin
            stateNext = IDLE;
            countNext = '0;
            ovfNext   = 1'b0;
            unfNext   = 1'b0;
            advA      = 1'b0;
            advB      = 1'b0;
        end

        addrANext = BufClr ? '0 : addrAReg + AW'(advA);
        addrBNext = BufClr ? '0 : addrBReg + AW'(advB);

        emptyNext = (countNext == '0);
        fullNext  = (countNext == DEPTH);
        rdyNext   = (stateNext == RD) && (countNext >= SECT);
        spcNext   = (stateNext == WR) && ((DEPTH - countNext) >= SECT);
        // Decodes are taken from the next address so the DMA engine sees flop outputs, never a gate glitch.
        wbbNext   = addrBNext[6] | addrBNext[5];
        bbeNext   = (addrBNext[4:0] == 5'h1F);
    end

    always_ff @(posedge CLK4 or posedge RST) begin
        if (RST) begin
            stateReg   <= IDLE;
            armPrevReg <= 1'b0;
            addrAReg   <= '0;
            addrBReg   <= '0;
            countReg   <= '0;
            ovfReg     <= 1'b0;
            unfReg     <= 1'b0;
            rdyReg     <= 1'b0;
            spcReg     <= 1'b0;
            wbbReg     <= 1'b0;
            bbeReg     <= 1'b0;
            emptyReg   <= 1'b1;
            fullReg    <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            armPrevReg <= DMA_ARM;
            addrAReg   <= addrANext;
            addrBReg   <= addrBNext;
            countReg   <= countNext;
            ovfReg     <= ovfNext;
            unfReg     <= unfNext;
            rdyReg     <= rdyNext;
            spcReg     <= spcNext;
            wbbReg     <= wbbNext;
            bbeReg     <= bbeNext;
            emptyReg   <= emptyNext;
            fullReg    <= fullNext;
        end
    end

    assign AddrA        = addrAReg;
    assign AddrB        = addrBReg;
    assign Count        = countReg;
    assign PB_OD_Rdy    = rdyReg;
    assign PB_HvSpace   = spcReg;
    assign WithinBBlock = wbbReg;
    assign BBurstEnd    = bbeReg;
    assign Empty        = emptyReg;
    assign Full         = fullReg;
    assign OvfErr       = ovfReg;
    assign UnfErr       = unfReg;

endmodule
